// File: rtl/zynet_pkg.sv
// Shared types and helpers for the zyNet frame sequencer.
package zynet_pkg;

  localparam int ZY_WORD_SIZE   = 16;
  localparam int ZY_OUTPUT_SIZE = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT,
    ARGMAX,
    RESULT
  } seq_state_e;

  typedef logic signed [ZY_OUTPUT_SIZE-1:0][ZY_WORD_SIZE-1:0] score_vec_t;

  function automatic int class_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/zynet_argmax_seq.sv
// Sequential argmax over a registered score vector, one signed compare per cycle.
module zynet_argmax_seq
  import zynet_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int OUTPUT_SIZE = 10,
  localparam int CLASS_W    = class_w(OUTPUT_SIZE)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             load_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] scores_i,
  output logic                             done_o,
  output logic [CLASS_W-1:0]               class_o,
  output logic [WORD_SIZE-1:0]             score_o
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(OUTPUT_SIZE - 1);

  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] scores_q, scores_d;
  logic [CLASS_W-1:0]                    idx_q, idx_d;
  logic [CLASS_W-1:0]                    best_idx_q, best_idx_d;
  logic signed [WORD_SIZE-1:0]           best_q, best_d;
  logic signed [WORD_SIZE-1:0]           cur;
  logic                                  active_q, active_d;

  assign cur    = $signed(scores_q[idx_q]);
  assign done_o = active_q && (idx_q == LAST_IDX);

  always_comb begin
    scores_d   = scores_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    active_d   = active_q;
    if (load_i) begin
      scores_d = scores_i;
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      // Index 0 seeds the running best; afterwards only a strictly larger score wins.
      if ((idx_q == '0) || (cur > best_q)) begin
        best_d     = cur;
        best_idx_d = idx_q;
      end
      if (done_o) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scores_q   <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      active_q   <= 1'b0;
    end else begin
      scores_q   <= scores_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      active_q   <= active_d;
    end
  end

  assign class_o = best_idx_q;
  assign score_o = best_q;

endmodule

// File: rtl/zynet_frame_sequencer.sv
// Frame sequencer: start pulse, gated sample stream, score pop, argmax, result hold.
// Optional WAIT watchdog enabled by defining ZYNET_SEQ_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for first sample of a frame (not consumed)
//  START  | one-cycle net_start_o pulse, sample counter cleared
//  STREAM | host samples passed through to the net until FRAME_LEN transfers
//  WAIT   | waiting for the net's score vector, popped on arrival
//  ARGMAX | sequential argmax over OUTPUT_SIZE scores
//  RESULT | result held until the host takes it
module zynet_frame_sequencer
  import zynet_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int OUTPUT_SIZE    = 10,
  parameter int FRAME_LEN      = 256,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CLASS_W       = class_w(OUTPUT_SIZE)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [WORD_SIZE-1:0]             data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic                             net_start_o,
  output logic [WORD_SIZE-1:0]             net_data_o,
  output logic                             net_valid_o,
  input  logic                             net_ready_i,
  input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] net_data_i,
  input  logic                             net_valid_i,
  output logic                             net_yumi_o,
  output logic [CLASS_W-1:0]               class_o,
  output logic [WORD_SIZE-1:0]             score_o,
  output logic                             error_o,
  output logic                             result_valid_o,
  input  logic                             result_ready_i,
  output logic                             busy_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;
  logic               timeout;
  logic               am_load;
  logic               am_done;
  logic [CLASS_W-1:0] am_class;
  logic [WORD_SIZE-1:0] am_score;

  assign xfer = valid_i & net_ready_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ready_o        = 1'b0;
    net_start_o    = 1'b0;
    net_data_o     = '0;
    net_valid_o    = 1'b0;
    net_yumi_o     = 1'b0;
    result_valid_o = 1'b0;
    am_load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) state_d = START;
      end
      START: begin
        net_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = STREAM;
      end
      STREAM: begin
        net_data_o  = data_i;
        net_valid_o = valid_i;
        ready_o     = net_ready_i;
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SAMPLE) state_d = WAIT;
        end
      end
      WAIT: begin
        // A score vector arriving on the watchdog's last cycle still completes normally.
        net_yumi_o = net_valid_i;
        if (net_valid_i) begin
          am_load = 1'b1;
          state_d = ARGMAX;
        end else if (timeout) begin
          state_d = RESULT;
        end
      end
      ARGMAX: begin
        if (am_done) state_d = RESULT;
      end
      RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE);

  zynet_argmax_seq #(
    .WORD_SIZE  (WORD_SIZE),
    .OUTPUT_SIZE(OUTPUT_SIZE)
  ) u_argmax (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (am_load),
    .scores_i (net_data_i),
    .done_o   (am_done),
    .class_o  (am_class),
    .score_o  (am_score)
  );

`ifdef ZYNET_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  assign timeout = (state_q == WAIT) && (wd_q == '0);

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    // Preloaded outside WAIT so the first WAIT cycle already holds the full count.
    if (state_q != WAIT) begin
      wd_d = WD_LOAD;
    end else if (wd_q != '0) begin
      wd_d = wd_q - 1'b1;
    end
    if (state_q == START) err_d = 1'b0;
    if (timeout && !net_valid_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign error_o = err_q;
  assign class_o = err_q ? '1 : am_class;
  assign score_o = err_q ? '0 : am_score;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign error_o        = 1'b0;
  assign class_o        = am_class;
  assign score_o        = am_score;
`endif

endmodule
